vga_pixel_shifter: RTL and testbench

// Text-mode pixel serializer downstream of the VGA timing generator. Each shload_n

---
 rtl/vga_pixel_shifter.sv | 113 +++++++++++
 tb/tb_vga_pixel_shifter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_shifter
// Description : Text-mode glyph serializer with attribute colouring, blinking
//               underline cursor and per-character blink, 4-bit colour index out.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_shifter #(
    parameter int BLINK_FRAMES = 16,
    parameter int CUR_LINE     = 7
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       shload_n,
    input  logic       blank,
    input  logic       vblank_n,
    input  logic [7:0] glyph,
    input  logic [7:0] attr,
    input  logic [6:0] cell_col,
    input  logic [8:0] cell_row,
    input  logic       cur_en,
    input  logic [6:0] cur_col,
    input  logic [5:0] cur_row,
    output logic [3:0] pix,
    output logic       pix_blank
);

    localparam int                 c_CNT_W    = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(BLINK_FRAMES - 1);
    localparam logic [2:0]         c_CUR_LINE = 3'(CUR_LINE);

    logic [7:0]         r_shreg;
    logic [3:0]         r_fg;
    logic [3:0]         r_bg;
    logic               r_cblink;
    logic               r_cur_hit;
    logic               r_vblank_q;
    logic [c_CNT_W-1:0] r_frame_cnt;
    logic               r_phase;
    logic [3:0]         r_pix;
    logic               r_pix_blank;

    logic               w_load;
    logic               w_cur_hit;
    logic               w_vfall;
    logic [3:0]         w_fg_eff;
    logic               w_on;

    assign w_load    = ~shload_n;
    assign w_cur_hit = cur_en
                     & (cell_col == cur_col)
                     & (cell_row[8:3] == cur_row)
                     & (cell_row[2:0] == c_CUR_LINE);
    assign w_vfall   = r_vblank_q & ~vblank_n;

    // Blinking characters show as background during the off phase
    assign w_fg_eff  = (r_cblink & ~r_phase) ? r_bg : r_fg;
    assign w_on      = r_shreg[7] | (r_cur_hit & r_phase);

    // Glyph shift register and latched cell attributes
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_shreg   <= 8'h00;
            r_fg      <= 4'h0;
            r_bg      <= 4'h0;
            r_cblink  <= 1'b0;
            r_cur_hit <= 1'b0;
        end else if (w_load) begin
            r_shreg   <= glyph;
            r_fg      <= attr[3:0];
            r_bg      <= {1'b0, attr[6:4]};
            r_cblink  <= attr[7];
            r_cur_hit <= w_cur_hit;
        end else begin
            r_shreg   <= {r_shreg[6:0], 1'b0};
        end
    end

    // Frame counter driving the shared cursor / character blink phase
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_vblank_q  <= 1'b1;
            r_frame_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_vblank_q <= vblank_n;
            if (w_vfall) begin
                if (r_frame_cnt == c_CNT_MAX) begin
                    r_frame_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    // Output pixel register
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_pix       <= 4'h0;
            r_pix_blank <= 1'b1;
        end else begin
            r_pix       <= blank ? 4'h0 : (w_on ? w_fg_eff : r_bg);
            r_pix_blank <= blank;
        end
    end

    assign pix       = r_pix;
    assign pix_blank = r_pix_blank;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pixel_shifter
// Description : Self-checking bench for vga_pixel_shifter against a cell-level
//               reference model, directed vectors plus randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_shifter;

    localparam int c_BLINK_FRAMES = 16;
    localparam int c_CUR_LINE     = 7;

    logic       pclk = 1'b0;
    logic       rst;
    logic       shload_n;
    logic       blank;
    logic       vblank_n;
    logic [7:0] glyph;
    logic [7:0] attr;
    logic [6:0] cell_col;
    logic [8:0] cell_row;
    logic       cur_en;
    logic [6:0] cur_col;
    logic [5:0] cur_row;
    logic [3:0] pix;
    logic       pix_blank;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the loaded cell plus how many pixels of it have been emitted
    logic [7:0] m_glyph;
    int         m_k;
    logic [3:0] m_fg;
    logic [3:0] m_bg;
    logic       m_cb;
    logic       m_hit;
    int         m_falls;
    logic       m_vprev;

    vga_pixel_shifter #(
        .BLINK_FRAMES (c_BLINK_FRAMES),
        .CUR_LINE     (c_CUR_LINE)
    ) u_dut (
        .pclk      (pclk),
        .rst       (rst),
        .shload_n  (shload_n),
        .blank     (blank),
        .vblank_n  (vblank_n),
        .glyph     (glyph),
        .attr      (attr),
        .cell_col  (cell_col),
        .cell_row  (cell_row),
        .cur_en    (cur_en),
        .cur_col   (cur_col),
        .cur_row   (cur_row),
        .pix       (pix),
        .pix_blank (pix_blank)
    );

    always #20 pclk = ~pclk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_glyph = 8'h00;
        m_k     = 8;
        m_fg    = 4'h0;
        m_bg    = 4'h0;
        m_cb    = 1'b0;
        m_hit   = 1'b0;
        m_falls = 0;
        m_vprev = 1'b1;
    endtask

    // One pclk: predict the pixel emitted at this edge, advance the model, compare
    task automatic tick();
        logic [3:0] e_pix;
        logic       e_blank;
        logic       ph;
        logic       bitv;
        logic       on;
        logic [3:0] fgeff;
        @(posedge pclk);
        if (rst) begin
            model_reset();
            e_pix   = 4'h0;
            e_blank = 1'b1;
        end else begin
            ph      = ((m_falls / c_BLINK_FRAMES) % 2) == 1;
            bitv    = (m_k < 8) ? m_glyph[7 - m_k] : 1'b0;
            fgeff   = (m_cb && !ph) ? m_bg : m_fg;
            on      = bitv | (m_hit & ph);
            e_pix   = blank ? 4'h0 : (on ? fgeff : m_bg);
            e_blank = blank;
            if (!shload_n) begin
                m_glyph = glyph;
                m_k     = 0;
                m_fg    = attr[3:0];
                m_bg    = {1'b0, attr[6:4]};
                m_cb    = attr[7];
                m_hit   = cur_en && (cell_col == cur_col) && (int'(cell_row) / 8 == int'(cur_row))
                          && (int'(cell_row) % 8 == c_CUR_LINE);
            end else if (m_k < 8) begin
                m_k++;
            end
            if (m_vprev && !vblank_n) m_falls++;
            m_vprev = vblank_n;
        end
        #1;
        chk("pix", {4'h0, pix}, {4'h0, e_pix});
        chk("pix_blank", {7'h0, pix_blank}, {7'h0, e_blank});
    endtask

    task automatic load(input logic [7:0] g, input logic [7:0] a, input logic [6:0] col,
                        input logic [8:0] row);
        glyph    = g;
        attr     = a;
        cell_col = col;
        cell_row = row;
        shload_n = 1'b0;
        tick();
        shload_n = 1'b1;
    endtask

    task automatic frame_falls(input int n);
        for (int i = 0; i < n; i++) begin
            vblank_n = 1'b0;
            tick();
            vblank_n = 1'b1;
            tick();
        end
    endtask

    // Load a cell and require a constant colour on all 8 of its pixels
    task automatic cell_const(input string tag, input logic [7:0] g, input logic [7:0] a,
                              input logic [6:0] col, input logic [8:0] row,
                              input logic [3:0] want);
        load(g, a, col, row);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk(tag, {4'h0, pix}, {4'h0, want});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a5_exp [8];
        a5_exp = '{4'hF, 4'h1, 4'hF, 4'h1, 4'h1, 4'hF, 4'h1, 4'hF};

        rst      = 1'b1;
        shload_n = 1'b1;
        blank    = 1'b0;
        vblank_n = 1'b1;
        glyph    = 8'h00;
        attr     = 8'h00;
        cell_col = 7'd0;
        cell_row = 9'd0;
        cur_en   = 1'b0;
        cur_col  = 7'd0;
        cur_row  = 6'd0;
        model_reset();
        #5;
        chk("reset_pix", {4'h0, pix}, 8'h00);
        chk("reset_blank", {7'h0, pix_blank}, 8'h01);
        tick();
        tick();
        #5 rst = 1'b0;

        // Basic serialization, MSB first, one pclk after the load edge
        load(8'hA5, 8'h1F, 7'd0, 9'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("a5_seq", {4'h0, pix}, {4'h0, a5_exp[i]});
        end

        // Blanked load
        blank = 1'b1;
        load(8'hFF, 8'h1F, 7'd0, 9'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("blank_pix", {4'h0, pix}, 8'h00);
            chk("blank_flag", {7'h0, pix_blank}, 8'h01);
        end
        blank = 1'b0;

        // Cursor underline: off in phase 0, drawn in fg once phase flips
        cur_en  = 1'b1;
        cur_col = 7'd5;
        cur_row = 6'd2;
        cell_const("cursor_ph0", 8'h00, 8'h0C, 7'd5, 9'd23, 4'h0);
        frame_falls(c_BLINK_FRAMES);
        cell_const("cursor_ph1", 8'h00, 8'h0C, 7'd5, 9'd23, 4'hC);
        cell_const("cursor_miss", 8'h00, 8'h0C, 7'd5, 9'd22, 4'h0);
        cur_en = 1'b0;

        // Character blink: visible in phase 1, background after the next flip
        cell_const("blink_on", 8'hFF, 8'h9E, 7'd1, 9'd0, 4'hE);
        frame_falls(c_BLINK_FRAMES);
        cell_const("blink_off", 8'hFF, 8'h9E, 7'd1, 9'd0, 4'h1);

        // Missing strobe: 8 px fg then background once the register drains
        load(8'hFF, 8'h1F, 7'd0, 9'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("drain", {4'h0, pix}, (i < 8) ? 8'h0F : 8'h01);
        end

        // Leave phase=1 with a part-way frame count, then reset mid-cell
        frame_falls(c_BLINK_FRAMES + 5);
        load(8'hFF, 8'h3A, 7'd0, 9'd0);
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        chk("rst_async_pix", {4'h0, pix}, 8'h00);
        chk("rst_async_blank", {7'h0, pix_blank}, 8'h01);
        tick();
        chk("rst_edge_pix", {4'h0, pix}, 8'h00);
        #5 rst = 1'b0;
        tick();
        chk("rst_drained", {4'h0, pix}, 8'h00);
        // phase and frame count restart from zero
        frame_falls(c_BLINK_FRAMES - 1);
        cell_const("rst_phase0", 8'hFF, 8'h9E, 7'd1, 9'd0, 4'h1);
        frame_falls(1);
        cell_const("rst_phase1", 8'hFF, 8'h9E, 7'd1, 9'd0, 4'hE);

        // Randomized traffic including back-to-back strobes and cursor hits
        for (int i = 0; i < 3000; i++) begin
            shload_n = ($urandom_range(0, 7) != 0);
            blank    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) == 0) vblank_n = ~vblank_n;
            glyph    = 8'($urandom);
            attr     = 8'($urandom);
            cell_col = 7'($urandom_range(0, 3));
            cell_row = 9'($urandom_range(0, 31));
            cur_en   = ($urandom_range(0, 3) != 0);
            cur_col  = 7'($urandom_range(0, 3));
            cur_row  = 6'($urandom_range(0, 3));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
